// File: rtl/ram_arbiter_if.sv
// Purpose: bundles the CPU port, loader port and RAM port of the data RAM arbiter.
// Latency: none; wires only.
// Backpressure: REQ is held by each requester until its ACK pulse.
interface ram_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_ack;
    logic [DW-1:0] ldr_rdata;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_in;
    logic          ram_wen;
    logic [DW-1:0] ram_out;

    logic          busy;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_ack, ldr_rdata,
        output ram_addr, ram_in, ram_wen,
        input  ram_out,
        output busy
    );

    // Requesters plus the RAM itself.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_ack, ldr_rdata,
        input  ram_addr, ram_in, ram_wen,
        output ram_out,
        input  busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Purpose: arbitrates CPU and loader transactions onto the single-port data RAM.
// Latency: write ACK 2 cycles after REQ is seen in IDLE, read ACK 2+RD_LAT cycles.
// Backpressure: requesters hold REQ until ACK; the losing REQ is re-arbitrated at the next IDLE.
module ram_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RD_LAT     = 1,   // 1..7
    parameter int STARVE_MAX = 4    // 1..15
) (
    input logic          clk,
    input logic          rst_n,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [2:0] WAIT_INIT  = 3'(RD_LAT - 1);

    state_t        state;
    logic [3:0]    starve;      // consecutive CPU grants taken while the loader was waiting
    logic [2:0]    wait_cnt;    // remaining read-latency cycles in WAIT_RD
    logic          sel_ldr;     // latched winner: 1 = loader
    logic          lat_we;      // latched write enable of the winner

    logic          any_req;
    logic          pick_ldr;
    logic          pick_we;
    logic [AW-1:0] pick_addr;
    logic [DW-1:0] pick_wdata;
    logic [3:0]    starve_nxt;

    // Choose the winner for a grant taken in IDLE and the starve count that follows it.
    always_comb begin
        any_req    = bus.cpu_req | bus.ldr_req;
        pick_ldr   = bus.ldr_req & (~bus.cpu_req | (starve == STARVE_LIM));
        pick_we    = pick_ldr ? bus.ldr_we    : bus.cpu_we;
        pick_addr  = pick_ldr ? bus.ldr_addr  : bus.cpu_addr;
        pick_wdata = pick_ldr ? bus.ldr_wdata : bus.cpu_wdata;
        if (pick_ldr || !bus.ldr_req) begin
            starve_nxt = '0;
        end else if (starve == STARVE_LIM) begin
            starve_nxt = starve;
        end else begin
            starve_nxt = starve + 4'd1;
        end
    end

    // Transaction sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            starve        <= '0;
            wait_cnt      <= '0;
            sel_ldr       <= 1'b0;
            lat_we        <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_in    <= '0;
            bus.ram_wen   <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.ldr_ack   <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.ldr_rdata <= '0;
            bus.busy      <= 1'b0;
        end else begin
            // ACKs are single-cycle pulses unless raised below.
            bus.cpu_ack <= 1'b0;
            bus.ldr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        // RAM address/data registers double as the latched request.
                        sel_ldr      <= pick_ldr;
                        lat_we       <= pick_we;
                        starve       <= starve_nxt;
                        bus.ram_addr <= pick_addr;
                        bus.ram_in   <= pick_wdata;
                        bus.ram_wen  <= pick_we;
                        bus.busy     <= 1'b1;
                        state        <= ACCESS;
                    end else begin
                        bus.ram_wen  <= 1'b0;
                    end
                end
                ACCESS: begin
                    bus.ram_wen <= 1'b0;
                    if (lat_we) begin
                        bus.cpu_ack <= ~sel_ldr;
                        bus.ldr_ack <= sel_ldr;
                        state       <= DONE;
                    end else begin
                        wait_cnt    <= WAIT_INIT;
                        state       <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (wait_cnt == 3'd0) begin
                        if (sel_ldr) begin
                            bus.ldr_rdata <= bus.ram_out;
                        end else begin
                            bus.cpu_rdata <= bus.ram_out;
                        end
                        bus.cpu_ack <= ~sel_ldr;
                        bus.ldr_ack <= sel_ldr;
                        state       <= DONE;
                    end else begin
                        wait_cnt    <= wait_cnt - 3'd1;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data RAM (ram_dc_wb).
- Requesters are the CPU data port (CPU_*) and the program/data loader (LDR_*).
- Serialises their read/write transactions onto one RAM port: RAM_ADDR, RAM_IN, RAM_WEN, RAM_OUT.
- Fixed CPU priority, with a starvation guard that forces a loader grant.

Parameters:
AW, 16, address width
DW, 16, data width
RD_LAT, 1, cycles from address presentation to valid RAM_OUT (1..7)
STARVE_MAX, 4, consecutive contested CPU grants after which the loader wins (1..15)

Ports:
CLK  in  1  single system clock, rising edge
RST_N  in  1  asynchronous active-low reset
CPU_REQ  in  1  CPU request, level, held until CPU_ACK
CPU_WE  in  1  1=write, 0=read; stable while CPU_REQ high
CPU_ADDR  in  AW  CPU address
CPU_WDATA  in  DW  CPU write data
CPU_ACK  out  1  one-cycle completion pulse
CPU_RDATA  out  DW  read data, valid when CPU_ACK=1
LDR_REQ, LDR_WE, LDR_ADDR, LDR_WDATA  in  1/1/AW/DW  loader request, same rules as CPU_*
LDR_ACK  out  1  one-cycle completion pulse
LDR_RDATA  out  DW  read data, valid when LDR_ACK=1
RAM_ADDR  out  AW  RAM address, registered
RAM_IN  out  DW  RAM write data, registered
RAM_WEN  out  1  RAM write enable, registered
RAM_OUT  in  DW  RAM read data
BUSY  out  1  high in any state except IDLE

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE; starve counter=0.
  - Forced to 0: RAM_ADDR, RAM_IN, RAM_WEN, CPU_ACK, LDR_ACK, CPU_RDATA, LDR_RDATA, BUSY.
  - Reset mid-transaction: RAM_WEN drops immediately and no ACK is issued. The requester's REQ is still high after reset release, so it is re-arbitrated from IDLE.
- States: IDLE, ACCESS, WAIT_RD, DONE. All outputs are registered.
- IDLE:
  - Samples CPU_REQ and LDR_REQ each cycle.
  - If either is high, selects a winner and latches winner, WE, ADDR and WDATA into internal registers; next state is ACCESS.
  - Otherwise stays in IDLE with RAM_WEN=0.
- Arbitration:
  - Only one REQ high: that requester wins.
  - Both high: CPU wins unless starve==STARVE_MAX, in which case the loader wins.
- Starve counter:
  - +1 (saturating at STARVE_MAX) on a CPU grant while LDR_REQ=1.
  - Cleared on a loader grant, and on a CPU grant with LDR_REQ=0.
- ACCESS (exactly 1 cycle):
  - RAM_ADDR and RAM_IN show the latched values.
  - RAM_WEN = latched WE, so it is high for exactly one cycle per write.
  - Write → DONE. Read → WAIT_RD with the wait counter loaded to RD_LAT-1.
- WAIT_RD:
  - RAM_WEN=0; RAM_ADDR is held.
  - When the wait counter reaches 0, RAM_OUT is captured into the winner's RDATA register and the state moves to DONE.
  - Otherwise the wait counter decrements.
  - RD_LAT=1: WAIT_RD lasts exactly one cycle.
- DONE (1 cycle):
  - Winner's ACK=1; the other ACK stays 0. Next state is IDLE.
  - RDATA holds its value until the next read by that requester; writes do not modify it.
- Latency, with REQ first seen in IDLE at cycle 0:
  - Write: RAM_WEN high in cycle 1, ACK in cycle 2.
  - Read: ACK in cycle 2+RD_LAT.
- Handshake:
  - Requester deasserts REQ in the cycle after it sees ACK.
  - A REQ still high when the arbiter is back in IDLE is a new transaction. Back-to-back throughput is 1 write per 3 cycles.
- The loser's REQ is ignored (not queued) until the next IDLE.
- Input changes while not in IDLE have no effect; values are latched only in IDLE.
- Address handling: full AW-bit pass-through, no range check. Addresses 64/65 (IO) are treated like any other address.

Test Plan:
- Reset, no REQ for 5 cycles → all outputs 0, BUSY=0, RAM_WEN never high.
- CPU write ADDR=0x0003, WDATA=0x0008 → cycle 1: RAM_ADDR=0x0003, RAM_IN=0x0008, RAM_WEN=1 for one cycle; cycle 2: CPU_ACK=1. Then CPU read of 0x0003 with RD_LAT=1 → CPU_ACK at cycle 3, CPU_RDATA=0x0008.
- CPU_REQ and LDR_REQ held high continuously, all writes, STARVE_MAX=4 → grant order CPU,CPU,CPU,CPU,LDR,CPU,... Exactly one ACK per DONE, never both.
- Only LDR_REQ high, read of 0x0041 (IO65 returns 0x1234), RD_LAT=3 → LDR_ACK 5 cycles after the request; LDR_RDATA=0x1234; CPU_RDATA unchanged.
- RST_N pulsed low during ACCESS of a write → RAM_WEN drops asynchronously; no ACK. After release with REQ still high, the write restarts from IDLE and completes with one ACK.
- Address 0xFFFF write followed by address 0x0000 read → both addresses are passed unmodified to RAM_ADDR; no wrap artefacts.
